vdp_io_master: RTL

//  Bus initiator that drives the VDP CPU-side IO register interface (data/ctrl ports) from a command stream.

---
 rtl/vdp_pkg.sv | 31 +++
 rtl/vdp_io_master.sv | 106 ++++++++++
 2 files changed

// File: rtl/vdp_pkg.sv
// vdp_pkg: command opcodes, VDP access codes, master FSM states and control-word builder
package vdp_pkg;

   localparam logic [2:0] OP_REG  = 3'd0;
   localparam logic [2:0] OP_VWR  = 3'd1;
   localparam logic [2:0] OP_PWR  = 3'd2;
   localparam logic [2:0] OP_VRD  = 3'd3;
   localparam logic [2:0] OP_STAT = 3'd4;

   localparam logic [1:0] CODE_VRD  = 2'd0;
   localparam logic [1:0] CODE_VWR  = 2'd1;
   localparam logic [1:0] CODE_REG  = 2'd2;
   localparam logic [1:0] CODE_CRAM = 2'd3;

   typedef enum logic [3:0] {
      IDLE, C0_WR, C0_DN, C1_WR, C1_DN, D_WAIT, D_WR, D_DN, R_WAIT, R_OUT, R_DN
   } state_t;

   // {byte1, byte0} of the two-byte control word for a command
   function automatic logic [15:0] ctrl_word(input logic [2:0] op, input logic [13:0] addr,
                                             input logic [7:0] val);
      case (op)
         OP_REG:  return {CODE_REG, 2'b00, addr[3:0], val};
         OP_VWR:  return {CODE_VWR, addr};
         OP_PWR:  return {CODE_CRAM, 6'd0, 3'd0, addr[4:0]};
         OP_VRD:  return {CODE_VRD, addr};
         default: return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/vdp_io_master.sv
// vdp_io_master: command-stream initiator driving the VDP CPU-side data/ctrl IO ports
module vdp_io_master
   import vdp_pkg::*;
#(
   parameter int RD_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [13:0] cmd_addr,
   input  logic [13:0] cmd_len,
   input  logic [7:0]  cmd_val,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        io_portsel,
   output logic [7:0]  io_wrdata,
   output logic        io_wren,
   output logic        io_wrdone,
   output logic        io_rddone,
   input  logic [7:0]  io_rddata
);

   state_t state, nxt;
   logic [2:0]  op, op_n;
   logic [13:0] addr, addr_n, len;
   logic [7:0]  val, val_n;
   logic [3:0]  wcnt;
   logic [15:0] cw;
   logic        accept, last, rd_go;

   assign cmd_ready = state == IDLE;
   assign busy      = !cmd_ready;
   assign wr_ready  = state == D_WAIT;
   assign rd_valid  = state == R_OUT;
   assign accept    = cmd_valid && cmd_ready;
   assign op_n      = accept ? cmd_op : op;
   assign addr_n    = accept ? cmd_addr : addr;
   assign val_n     = accept ? cmd_val : val;
   assign cw        = ctrl_word(op_n, addr_n, val_n);
   assign last      = len == 14'd1;
   assign rd_go     = wcnt == 4'(RD_WAIT - 1);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !cmd_valid ? IDLE : cmd_op == OP_STAT ? R_WAIT : cmd_op <= OP_VRD ? C0_WR : IDLE;
         C0_WR:   nxt = C0_DN;
         C0_DN:   nxt = C1_WR;
         C1_WR:   nxt = C1_DN;
         C1_DN:   nxt = (op == OP_REG || len == 14'd0) ? IDLE : op == OP_VRD ? R_WAIT : D_WAIT;
         D_WAIT:  nxt = wr_valid ? D_WR : D_WAIT;
         D_WR:    nxt = D_DN;
         D_DN:    nxt = last ? IDLE : D_WAIT;
         R_WAIT:  nxt = rd_go ? R_OUT : R_WAIT;
         R_OUT:   nxt = rd_ready ? R_DN : R_OUT;
         R_DN:    nxt = last ? IDLE : R_WAIT;
         default: nxt = IDLE;
      endcase
   end

   // io_* are registered from the next state so strobes line up with the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op         <= 3'd0;
         addr       <= 14'd0;
         val        <= 8'd0;
         len        <= 14'd0;
         wcnt       <= 4'd0;
         rd_data    <= 8'd0;
         io_portsel <= 1'b0;
         io_wrdata  <= 8'd0;
         io_wren    <= 1'b0;
         io_wrdone  <= 1'b0;
         io_rddone  <= 1'b0;
      end else begin
         state      <= nxt;
         io_wren    <= nxt inside {C0_WR, C1_WR, D_WR};
         io_wrdone  <= nxt inside {C0_DN, C1_DN, D_DN};
         io_rddone  <= nxt == R_DN;
         io_portsel <= nxt inside {C0_WR, C0_DN, C1_WR, C1_DN} ||
                       (nxt inside {R_WAIT, R_OUT, R_DN} && op_n == OP_STAT);
         io_wrdata  <= nxt inside {C0_WR, C0_DN} ? cw[7:0] :
                       nxt inside {C1_WR, C1_DN} ? cw[15:8] :
                       (state == D_WAIT && wr_valid) ? wr_data : io_wrdata;
         wcnt       <= state == R_WAIT ? wcnt + 4'd1 : 4'd0;
         if (state == R_WAIT && rd_go) rd_data <= io_rddata;
         if (accept) begin
            op   <= cmd_op;
            addr <= cmd_addr;
            val  <= cmd_val;
            len  <= cmd_op == OP_STAT ? 14'd1 : cmd_len;
         end else if (state inside {D_DN, R_DN}) begin
            len <= len - 14'd1;
         end
      end
   end

endmodule
